// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg
//   Shared definitions for the ROM loader: default geometry, the bytes-per-word
//   constant, a helper that derives bytes-per-word from a word width, and the
//   loader state encoding.
package rom_loader_pkg;

    localparam int ADDR_W_DEF     = 6;
    localparam int DATA_W_DEF     = 32;
    localparam int BYTES_PER_WORD = DATA_W_DEF / 8;

    //  state   | meaning
    //  IDLE    | waiting for start, all outputs quiet
    //  COLLECT | accepting host bytes into the packer
    //  WRITE   | one-cycle ROM write of the assembled word
    //  VRD     | readback: present verify address to the ROM
    //  VCMP    | readback: accumulate ROM data into verify sum
    //  DONE    | load finished successfully (done held)
    //  ERR     | bad word count or verify mismatch (err held)
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        VRD     = 3'd3,
        VCMP    = 3'd4,
        DONE    = 3'd5,
        ERR     = 3'd6
    } state_t;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/rom_loader_byte_packer.sv
// byte_packer
//   Assembles a little-endian byte stream into DATA_W-bit words. The first
//   byte of a word lands in bits [7:0]. o_word_valid is asserted in the same
//   cycle the final byte of a word is transferred; o_word holds the complete
//   word from the following cycle until the next word starts filling.
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_clr         : restart assembly at byte 0 (new load)
//   i_fire        : a byte transfers this cycle
//   i_byte        : byte data
//   o_word        : assembled word register
//   o_word_valid  : last byte of a word transfers this cycle
module byte_packer import rom_loader_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_fire,
    input  logic [7:0]        i_byte,
    output logic [DATA_W-1:0] o_word,
    output logic              o_word_valid
);

    localparam int BPW   = bytes_per_word(DATA_W);
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BPW - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_fire) begin
            for (int b = 0; b < BPW; b++) begin
                if (r_cnt == CNT_W'(b)) begin
                    r_word[8*b +: 8] <= i_byte;
                end
            end
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = i_fire && (r_cnt == LAST);

endmodule

// File: rtl/rom_loader.sv
// rom_loader
//   Loads a word-addressed ROM from a host byte stream while holding the
//   target system in reset. Words are written to consecutive addresses from 0
//   and summed into checksum. With ROM_LOADER_VERIFY_EN defined, the written
//   words are read back after the last write and their sum compared with
//   checksum; a mismatch ends in ERR. Without the macro the load ends in DONE
//   after the last write and ERR is reached only for an invalid word count.
// Ports
//   sys_clk, sys_rst_n        : clock, asynchronous active-low reset
//   start, target_sel         : load request and ROM select (captured on accept)
//   word_count                : words to load, valid 1..2^ADDR_W
//   in_valid/in_data/in_ready : host byte stream, valid-ready
//   rom_we/rom_select/rom_addr/rom_wd : ROM load port
//   rom_rd                    : ROM read data (combinational from addr/select)
//   hold_rst, busy            : asserted while a load is in progress
//   done, err                 : completion status, held until next accepted start
//   checksum                  : running sum of written words
module rom_loader import rom_loader_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic              target_sel,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              rom_we,
    output logic              rom_select,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] rom_wd,
    input  logic [DATA_W-1:0] rom_rd,
    output logic              hold_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_cnt_ok;
    logic              w_fire;
    logic              w_word_valid;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] r_checksum;
    logic              r_target;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_idx;
    logic [ADDR_W:0]   w_idx_inc;

    assign w_cnt_ok  = (word_count != '0) && (word_count <= MAX_CNT);
    // idx is one bit wider than the address so a full 2^ADDR_W load ends
    // with idx == count instead of wrapping back to 0.
    assign w_idx_inc = r_idx + 1'b1;
    assign w_fire    = in_valid && in_ready;

    byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clk          (sys_clk),
        .rst_n        (sys_rst_n),
        .i_clr        (w_accept),
        .i_fire       (w_fire),
        .i_byte       (in_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

`ifdef ROM_LOADER_VERIFY_EN
    logic [ADDR_W:0]   r_vidx;
    logic [ADDR_W:0]   w_vidx_inc;
    logic [DATA_W-1:0] r_vsum;
    logic [DATA_W-1:0] w_vsum_nxt;

    assign w_vidx_inc = r_vidx + 1'b1;
    assign w_vsum_nxt = r_vsum + rom_rd;
`else
    logic w_unused_rd;
    assign w_unused_rd = ^rom_rd;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_cnt_ok ? COLLECT : ERR;
                end
            end
            COLLECT: begin
                if (w_word_valid) begin
                    w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (w_idx_inc < r_count) begin
                    w_state_nxt = COLLECT;
                end else begin
`ifdef ROM_LOADER_VERIFY_EN
                    w_state_nxt = VRD;
`else
                    w_state_nxt = DONE;
`endif
                end
            end
`ifdef ROM_LOADER_VERIFY_EN
            VRD: begin
                w_state_nxt = VCMP;
            end
            VCMP: begin
                if (w_vidx_inc < r_count) begin
                    w_state_nxt = VRD;
                end else if (w_vsum_nxt == r_checksum) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = ERR;
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        rom_we     = 1'b0;
        rom_select = 1'b0;
        rom_addr   = '0;
        rom_wd     = '0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (r_state)
            COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            WRITE: begin
                rom_we     = 1'b1;
                rom_select = r_target;
                rom_addr   = r_idx[ADDR_W-1:0];
                rom_wd     = w_word;
                busy       = 1'b1;
            end
`ifdef ROM_LOADER_VERIFY_EN
            // Address held through VCMP so rom_rd is still valid when summed.
            VRD, VCMP: begin
                rom_select = r_target;
                rom_addr   = r_vidx[ADDR_W-1:0];
                busy       = 1'b1;
            end
`endif
            DONE: begin
                done = 1'b1;
            end
            ERR: begin
                err = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign hold_rst = busy;
    assign checksum = r_checksum;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_target   <= 1'b0;
            r_count    <= '0;
            r_idx      <= '0;
            r_checksum <= '0;
`ifdef ROM_LOADER_VERIFY_EN
            r_vidx     <= '0;
            r_vsum     <= '0;
`endif
        end else if (w_accept) begin
            r_target   <= target_sel;
            r_count    <= word_count;
            r_idx      <= '0;
            r_checksum <= '0;
`ifdef ROM_LOADER_VERIFY_EN
            r_vidx     <= '0;
            r_vsum     <= '0;
`endif
        end else if (r_state == WRITE) begin
            r_checksum <= r_checksum + w_word;
            r_idx      <= w_idx_inc;
        end
`ifdef ROM_LOADER_VERIFY_EN
        else if (r_state == VCMP) begin
            r_vsum <= w_vsum_nxt;
            r_vidx <= w_vidx_inc;
        end
`endif
    end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader
//   Self-checking bench for rom_loader. A scoreboard of expected ROM writes
//   (select, address, word) is built from the word list of each load; the
//   expected checksum is the plain sum of those words. A behavioural ROM
//   stores writes and serves combinational readback, with an optional
//   corruption of address 3 for the verify-failure case.
module tb_rom_loader;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          sys_clk    = 1'b0;
    logic          sys_rst_n  = 1'b0;
    logic          start      = 1'b0;
    logic          target_sel = 1'b0;
    logic [AW:0]   word_count = '0;
    logic          in_valid   = 1'b0;
    logic [7:0]    in_data    = '0;
    logic          in_ready;
    logic          rom_we;
    logic          rom_select;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_wd;
    logic [DW-1:0] rom_rd;
    logic          hold_rst;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] checksum;

    rom_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .start      (start),
        .target_sel (target_sel),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .rom_we     (rom_we),
        .rom_select (rom_select),
        .rom_addr   (rom_addr),
        .rom_wd     (rom_wd),
        .rom_rd     (rom_rd),
        .hold_rst   (hold_rst),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .checksum   (checksum)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural ROM pair
    logic [DW-1:0] rom_mem [2][64];
    bit            corrupt = 1'b0;

    always @(posedge sys_clk) begin
        if (rom_we) rom_mem[rom_select][rom_addr] <= rom_wd;
    end

    always_comb begin
        rom_rd = rom_mem[rom_select][rom_addr];
        if (corrupt && rom_addr == 6'd3) rom_rd = rom_rd ^ 32'h0000_0100;
    end

    // Write scoreboard
    typedef struct {
        bit            sel;
        int            addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_we      = 0;
    bit  hold_seen = 1'b0;

    always @(negedge sys_clk) begin
        if (hold_rst) hold_seen <= 1'b1;
        if (rom_we) begin
            wr_t e;
            n_we <= n_we + 1;
            if (exp_q.size() == 0) begin
                check_val("we_unexpected", 64'(rom_we), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("wr_addr", 64'(rom_addr), 64'(e.addr));
                check_val("wr_data", 64'(rom_wd), 64'(e.data));
                check_val("wr_sel", 64'(rom_select), 64'(e.sel));
            end
        end
    end

    logic [DW-1:0] wbuf [64];

    task automatic do_start(input bit sel, input logic [AW:0] cnt);
        start      = 1'b1;
        target_sel = sel;
        word_count = cnt;
        @(posedge sys_clk); #1;
        start      = 1'b0;
        target_sel = 1'($urandom);
        word_count = 7'($urandom);
    endtask

    // Offer one byte, optionally with random idle cycles and random start
    // noise (start/target/count toggling while the loader is busy).
    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit noise);
        bit sent  = 1'b0;
        int guard = 0;
        while (!sent) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = in_valid ? b : 8'($urandom);
            if (noise) begin
                start      = 1'($urandom);
                target_sel = 1'($urandom);
                word_count = 7'($urandom);
            end
            @(negedge sys_clk);
            sent = in_valid && in_ready;
            @(posedge sys_clk); #1;
            guard++;
            if (!sent && guard > 100) begin
                check_val("byte_timeout", 64'(in_ready), 64'd1);
                break;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_end(input int limit);
        int t = 0;
        while (!(done || err) && t < limit) begin
            @(posedge sys_clk); #1;
            t++;
        end
        if (!(done || err)) check_val("end_timeout", 64'(done | err), 64'd1);
    endtask

    task automatic load_run(input bit sel, input int cnt, input bit gaps, input bit noise,
                            input bit exp_err);
        logic [DW-1:0] sum = '0;
        int            we0 = n_we;
        for (int i = 0; i < cnt; i++) begin
            exp_q.push_back('{sel, i, wbuf[i]});
            sum += wbuf[i];
        end
        do_start(sel, 7'(cnt));
        check_val("busy_after_start", 64'({busy, hold_rst}), 64'd3);
        for (int i = 0; i < cnt; i++) begin
            for (int k = 0; k < 4; k++) send_byte(wbuf[i][8*k +: 8], gaps, noise);
        end
        wait_end(4 * cnt + 20);
        check_val("done", 64'(done), 64'(!exp_err));
        check_val("err", 64'(err), 64'(exp_err));
        check_val("checksum", 64'(checksum), 64'(sum));
        check_val("we_count", 64'(n_we - we0), 64'(cnt));
        check_val("q_empty", 64'(exp_q.size()), 64'd0);
        check_val("idle_flags", 64'({busy, hold_rst, in_ready}), 64'd0);
    endtask

    initial begin
        // Reset state
        #12;
        check_val("rst_flags", 64'({rom_we, in_ready, busy, hold_rst, done, err, rom_select}), 64'd0);
        check_val("rst_bus", 64'({rom_addr, rom_wd}), 64'd0);
        check_val("rst_checksum", 64'(checksum), 64'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        // Single word, little-endian assembly
        wbuf[0] = 32'h1234_5678;
        load_run(1'b0, 1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge sys_clk);
        #1;
        check_val("done_held", 64'({done, err}), 64'd2);

        // Full 64-word load with random stalls
        for (int i = 0; i < 64; i++) wbuf[i] = 32'hA000_0000 + 32'(i);
        load_run(1'b1, 64, 1'b1, 1'b0, 1'b0);

        // Random loads
        for (int r = 0; r < 4; r++) begin
            int c;
            c = $urandom_range(1, 12);
            for (int i = 0; i < c; i++) wbuf[i] = $urandom;
            load_run(1'($urandom), c, 1'b1, 1'b0, 1'b0);
        end

        // Invalid word counts
        begin
            logic [AW:0] bad [2];
            bad[0] = 7'd0;
            bad[1] = 7'd65;
            for (int j = 0; j < 2; j++) begin
                int we0;
                we0       = n_we;
                hold_seen = 1'b0;
                do_start(1'b0, bad[j]);
                check_val("bad_cnt_err", 64'({err, done, busy}), 64'd4);
                repeat (4) @(posedge sys_clk);
                #1;
                check_val("bad_cnt_we", 64'(n_we - we0), 64'd0);
                check_val("bad_cnt_hold", 64'(hold_seen), 64'd0);
            end
        end

        // Reset in the middle of a load
        begin
            int we0;
            for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
            for (int i = 0; i < 4; i++) exp_q.push_back('{1'b0, i, wbuf[i]});
            do_start(1'b0, 7'd4);
            for (int i = 0; i < 2; i++)
                for (int k = 0; k < 4; k++) send_byte(wbuf[i][8*k +: 8], 1'b0, 1'b0);
            @(posedge sys_clk); #1;
            send_byte(wbuf[2][7:0], 1'b0, 1'b0);
            #2;
            sys_rst_n = 1'b0;
            #1;
            check_val("midrst_flags", 64'({rom_we, in_ready, busy, hold_rst, done, err, rom_select}), 64'd0);
            check_val("midrst_checksum", 64'(checksum), 64'd0);
            check_val("midrst_written", 64'(exp_q.size()), 64'd2);
            exp_q.delete();
            we0 = n_we;
            repeat (2) @(posedge sys_clk);
            @(negedge sys_clk);
            sys_rst_n = 1'b1;
            @(posedge sys_clk); #1;
            check_val("midrst_no_we", 64'(n_we - we0), 64'd0);
            wbuf[0] = $urandom;
            wbuf[1] = $urandom;
            load_run(1'b1, 2, 1'b1, 1'b0, 1'b0);
        end

        // start toggling while busy is ignored
        wbuf[0] = 32'hCAFE_0001;
        wbuf[1] = 32'hCAFE_0002;
        load_run(1'b0, 2, 1'b1, 1'b1, 1'b0);

`ifdef ROM_LOADER_VERIFY_EN
        // Readback corruption at address 3 must end in ERR
        for (int i = 0; i < 6; i++) wbuf[i] = $urandom;
        corrupt = 1'b1;
        load_run(1'b1, 6, 1'b1, 1'b0, 1'b1);
        corrupt = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
